// File: rtl/rs422_frame_pkg.sv
// Shared definitions for the RS422 frame link (transmit framer and receive-side decoder).
// Holds the frame delimiter bytes, the character length and the framer FSM encoding.
package rs422_frame_pkg;

  localparam logic [7:0]  HDR0          = 8'hAA;
  localparam logic [7:0]  HDR1          = 8'h55;
  localparam logic [7:0]  TAIL          = 8'hEF;
  localparam int unsigned BITS_PER_CHAR = 10;

  // StWait is the payload underrun hold: line at mark, DE high, tx_ready high.
  typedef enum logic [3:0] {
    StIdle,
    StGuardPre,
    StHdr0,
    StHdr1,
    StLen,
    StPayload,
    StWait,
    StCsum,
    StTail,
    StGuardPost
  } tx_state_e;

endpackage

// File: rtl/uart_tx_shifter.sv
// UART character serialiser: start(0), d7..d0 MSB first, stop(1).
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   load           : start a new character next cycle (takes priority over everything)
//   byte_in        : character to send, sampled with load
//   idle           : high in the last cycle of the stop bit; a load here gives back-to-back chars
//   txd            : serial output, mark (1) when not sending
module uart_tx_shifter
  import rs422_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       idle,
  output logic       txd
);

  localparam int unsigned CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BaudMax = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    StopIdx = 4'(BITS_PER_CHAR - 1);

  logic [CW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [8:0]    sh_q;    // remaining data bits followed by the stop bit
  logic          active_q;
  logic          txd_q;
  logic          bit_end;

  assign bit_end = active_q && (baud_q == BaudMax);
  assign idle    = bit_end && (bit_q == StopIdx);
  assign txd     = txd_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      active_q <= 1'b0;
      txd_q    <= 1'b1;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= '1;
    end else if (load) begin
      // Counters restart on every load, so timing never accumulates error.
      active_q <= 1'b1;
      txd_q    <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      sh_q     <= {byte_in, 1'b1};
    end else if (bit_end) begin
      baud_q <= '0;
      if (bit_q == StopIdx) begin
        active_q <= 1'b0;  // txd already at stop level, stays at mark
      end else begin
        txd_q <= sh_q[8];
        sh_q  <= {sh_q[7:0], 1'b1};
        bit_q <= bit_q + 4'd1;
      end
    end else if (active_q) begin
      baud_q <= baud_q + 1'b1;
    end
  end

endmodule

// File: rtl/rs422_frame_tx.sv
// Half-duplex RS422 frame transmitter: sends AA 55 LEN payload CSUM EF and drives DE/RE_n.
// Ports:
//   clk_in, rst_in        : clock, synchronous active-high reset
//   start, len            : frame request and payload length (sampled only when idle)
//   tx_data/valid/ready   : payload byte handshake
//   busy, done, len_err   : status; done pulses as DE drops, len_err on rejected length
//   rs422_de, rs422_re_n  : transceiver enables (identical, half duplex)
//   rs422_di              : serial line, mark = 1
module rs422_frame_tx
  import rs422_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned LEN_W        = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic             done,
  output logic             len_err,
  output logic             rs422_de,
  output logic             rs422_re_n,
  output logic             rs422_di
);

  localparam int unsigned   CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CntMax = CW'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, idx_q;
  logic [7:0]       csum_q;
  logic             done_q, len_err_q;
  logic             len_bad, accept, load, shift_idle;
  logic [7:0]       load_byte;

  assign len_bad = len > LEN_W'(MAX_LEN);
  assign accept  = tx_ready && tx_valid;
  assign done    = done_q;
  assign len_err = len_err_q;

  uart_tx_shifter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_shifter (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (load),
    .byte_in(load_byte),
    .idle   (shift_idle),
    .txd    (rs422_di)
  );

  // State register plus frame datapath.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= (state_q == StGuardPost) && (cnt_q == CntMax);
      len_err_q <= (state_q == StIdle) && start && len_bad;
      if ((state_q == StIdle) && start && !len_bad) begin
        len_q  <= len;
        idx_q  <= '0;
        csum_q <= 8'(len);  // checksum covers LEN and payload only
      end else if (accept) begin
        idx_q  <= idx_q + 1'b1;
        csum_q <= csum_q + tx_data;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start && !len_bad) begin
          state_d = StGuardPre;
          cnt_d   = '0;
        end
      end
      StGuardPre: begin
        if (cnt_q == CntMax) state_d = StHdr0;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      StHdr0: if (shift_idle) state_d = StHdr1;
      StHdr1: if (shift_idle) state_d = StLen;
      // idx_q is 0 in StLen, so len=0 falls straight through to the checksum.
      StLen, StPayload: begin
        if (shift_idle) begin
          if (idx_q == len_q) state_d = StCsum;
          else if (tx_valid)  state_d = StPayload;
          else                state_d = StWait;
        end
      end
      StWait: if (tx_valid) state_d = StPayload;
      StCsum: if (shift_idle) state_d = StTail;
      StTail: begin
        if (shift_idle) begin
          state_d = StGuardPost;
          cnt_d   = '0;
        end
      end
      StGuardPost: begin
        if (cnt_q == CntMax) state_d = StIdle;
        else                 cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: shifter loads, handshake, transceiver enables.
  always_comb begin
    load       = 1'b0;
    load_byte  = 8'hFF;
    tx_ready   = 1'b0;
    busy       = (state_q != StIdle);
    rs422_de   = busy;
    rs422_re_n = busy;
    unique case (state_q)
      StGuardPre: begin
        load      = (cnt_q == CntMax);
        load_byte = HDR0;
      end
      StHdr0: begin
        load      = shift_idle;
        load_byte = HDR1;
      end
      StHdr1: begin
        load      = shift_idle;
        load_byte = 8'(len_q);
      end
      StLen, StPayload: begin
        if (shift_idle) begin
          if (idx_q == len_q) begin
            load      = 1'b1;
            load_byte = csum_q;
          end else begin
            // Fetch cycle coincides with the stop bit's last cycle: no gap when data is ready.
            tx_ready  = 1'b1;
            load      = tx_valid;
            load_byte = tx_data;
          end
        end
      end
      StWait: begin
        tx_ready  = 1'b1;
        load      = tx_valid;
        load_byte = tx_data;
      end
      StCsum: begin
        load      = shift_idle;
        load_byte = TAIL;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rs422_frame_tx.sv
module tb_rs422_frame_tx;

  localparam int CPB = 16;

  typedef struct packed {
    logic [7:0] val;
    logic       pl;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic       start = 1'b0;
  logic [4:0] len = '0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, len_err, rs422_de, rs422_re_n, rs422_di;

  rs422_frame_tx #(
    .CLKS_PER_BIT(CPB),
    .MAX_LEN     (16),
    .LEN_W       (5)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .start     (start),
    .len       (len),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err),
    .rs422_de  (rs422_de),
    .rs422_re_n(rs422_re_n),
    .rs422_di  (rs422_di)
  );

  always #5 clk_in = ~clk_in;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [7:0] pay[0:15];

  // Monitor state
  bit         prev_de = 1'b0;
  bit         first_byte = 1'b0;
  bit         in_byte = 1'b0;
  bit         stable;
  bit         rdy_seen = 1'b0;
  int         rise_cyc = 0;
  int         last_end = 0;
  int         hs_cyc = 0;
  int         k = 0;
  int         done_cnt = 0;
  logic       bitval;
  logic [7:0] sh;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // Monitor: decodes the serial line, checks timing, pops the scoreboard.
  always @(negedge clk_in) begin
    int   e;
    exp_t cur;
    if (rst_in) begin
      in_byte    = 1'b0;
      first_byte = 1'b0;
      prev_de    = rs422_de;
    end else begin
      chk("re_n_eq_de", int'(rs422_re_n), int'(rs422_de));
      chk("busy_eq_de", int'(busy), int'(rs422_de));
      if (done) done_cnt++;
      if (tx_ready) rdy_seen = 1'b1;
      if (tx_ready && tx_valid) hs_cyc = cyc;
      if (rs422_de && !prev_de) begin
        rise_cyc   = cyc;
        first_byte = 1'b1;
      end
      if (!rs422_de && prev_de) begin
        chk("post_guard_len", cyc - last_end - 1, CPB);
        chk("done_at_de_fall", int'(done), 1);
      end
      prev_de = rs422_de;
      if (!in_byte) begin
        if (rs422_di == 1'b0) begin
          in_byte = 1'b1;
          k       = 0;
          stable  = 1'b1;
          bitval  = 1'b0;
          sh      = '0;
          chk("de_during_char", int'(rs422_de), 1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_char: start bit at cycle %0d, expected none", cyc);
          end else if (first_byte) begin
            chk("pre_guard_len", cyc - rise_cyc, CPB);
            first_byte = 1'b0;
          end else if (exp_q[0].pl) begin
            e = last_end + 1;
            if (hs_cyc + 1 > e) e = hs_cyc + 1;
            chk("payload_slot_start", cyc, e);
          end else begin
            chk("back_to_back", cyc, last_end + 1);
          end
        end
      end else begin
        k++;
        if (k % CPB == 0) begin
          bitval = rs422_di;
          if (k / CPB >= 1 && k / CPB <= 8) sh = {sh[6:0], rs422_di};
        end else if (rs422_di !== bitval) begin
          stable = 1'b0;
        end
        if (k == 10 * CPB - 1) begin
          in_byte  = 1'b0;
          last_end = cyc;
          chk("bit_stable", int'(stable), 1);
          chk("stop_bit", int'(bitval), 1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            chk("char_value", int'(sh), int'(cur.val));
          end
        end
      end
    end
  end

  // Drives one frame from pay[0:n-1]. Entered and left at posedge+1; returns in the cycle after done.
  task automatic run_frame(input int n, input int under_idx, input int gap, input bit busy_poke);
    int sum;
    int t;
    int d0;
    exp_q.push_back('{val: 8'hAA, pl: 1'b0});
    exp_q.push_back('{val: 8'h55, pl: 1'b0});
    exp_q.push_back('{val: 8'(n), pl: 1'b0});
    sum = n;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{val: pay[i], pl: 1'b1});
      sum += int'(pay[i]);
    end
    exp_q.push_back('{val: 8'(sum % 256), pl: 1'b0});
    exp_q.push_back('{val: 8'hEF, pl: 1'b0});
    d0       = done_cnt;
    rdy_seen = 1'b0;
    start    = 1'b1;
    len      = 5'(n);
    @(posedge clk_in); #1;
    start = 1'b0;
    len   = 5'($urandom_range(0, 31));
    if (busy_poke) begin
      repeat (50) @(posedge clk_in);
      #1 start = 1'b1;
      len = 5'd3;
      @(posedge clk_in); #1;
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      tx_data = pay[i];
      if (i == under_idx) begin
        tx_valid = 1'b0;
        t = 0;
        while (!tx_ready && t < 5000) begin
          @(posedge clk_in); #1;
          t++;
        end
        repeat (gap) begin
          @(posedge clk_in); #1;
        end
      end
      tx_valid = 1'b1;
      t = 0;
      while (t < 5000) begin
        if (tx_ready) begin
          @(posedge clk_in); #1;
          break;
        end
        @(posedge clk_in); #1;
        t++;
      end
      if (t >= 5000) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: byte %0d not accepted, expected within 5000 cycles", i);
      end
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
    end
    t = 0;
    while (done_cnt == d0 && t < 20000) begin
      @(posedge clk_in);
      t++;
    end
    #1;
    chk("done_once", done_cnt - d0, 1);
  endtask

  initial begin
    int n;
    int ui;
    repeat (5) @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    chk("rst_di", int'(rs422_di), 1);
    chk("rst_de", int'(rs422_de), 0);
    chk("rst_re_n", int'(rs422_re_n), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_len_err", int'(len_err), 0);
    chk("rst_tx_ready", int'(tx_ready), 0);
    @(posedge clk_in); #1;

    // Basic frame: AA 55 02 01 02 05 EF
    pay[0] = 8'h01; pay[1] = 8'h02;
    run_frame(2, -1, 0, 1'b0);
    repeat (3) @(posedge clk_in); #1;

    // Checksum wrap: FF+FF+2 -> 00
    pay[0] = 8'hFF; pay[1] = 8'hFF;
    run_frame(2, -1, 0, 1'b0);
    repeat (3) @(posedge clk_in); #1;

    // Empty payload
    run_frame(0, -1, 0, 1'b0);
    chk("len0_no_ready", int'(rdy_seen), 0);
    repeat (3) @(posedge clk_in); #1;

    // Underrun of 40 cycles at the second payload byte
    for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
    run_frame(4, 1, 40, 1'b0);
    repeat (3) @(posedge clk_in); #1;

    // Oversized length is rejected
    start = 1'b1;
    len   = 5'd17;
    @(posedge clk_in); #1;
    start = 1'b0;
    @(negedge clk_in);
    chk("len_err_pulse", int'(len_err), 1);
    chk("len_err_de_low", int'(rs422_de), 0);
    @(negedge clk_in);
    chk("len_err_one_cycle", int'(len_err), 0);
    repeat (5) @(negedge clk_in);
    chk("len_err_no_frame", int'(busy), 0);
    @(posedge clk_in); #1;

    // Start while busy is ignored
    for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
    run_frame(5, -1, 0, 1'b1);
    repeat (3) @(posedge clk_in); #1;

    // Reset during the third data bit of HDR1, then a fresh frame
    exp_q.push_back('{val: 8'hAA, pl: 1'b0});
    exp_q.push_back('{val: 8'h55, pl: 1'b0});
    start = 1'b1;
    len   = 5'd2;
    @(posedge clk_in); #1;
    start = 1'b0;
    repeat (232) @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("abort_di", int'(rs422_di), 1);
    chk("abort_de", int'(rs422_de), 0);
    chk("abort_re_n", int'(rs422_re_n), 0);
    chk("abort_busy", int'(busy), 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    chk("abort_pending_chars", exp_q.size(), 1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
    run_frame(3, -1, 0, 1'b0);

    // Back-to-back: start in the cycle after done, 16 bytes 00..0F (CSUM 0x88)
    for (int i = 0; i < 16; i++) pay[i] = 8'(i);
    run_frame(16, -1, 0, 1'b0);
    repeat (3) @(posedge clk_in); #1;

    // Randomized frames with occasional underruns
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(0, 16);
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      ui = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
      run_frame(n, ui, int'($urandom_range(1, 30)), 1'b0);
      repeat ($urandom_range(0, 4)) @(posedge clk_in);
      #1;
    end

    repeat (30) @(posedge clk_in);
    #1 chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
